// File: rtl/casino_pkg.sv
// Shared types and constants for the casino game selector: FSM states,
// error codes and the blank display pattern.
package casino_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RUNNING = 2'd2,
    SETTLE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_SEL     = 2'd1,
    ERR_BET     = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_e;

  // Widest display bus supported; the top slices the low DISP_W bits.
  localparam int DISP_MAX_W = 64;

  // Seven-segment digits are active-low, so all ones is a dark board.
  localparam logic [DISP_MAX_W-1:0] DISP_BLANK = '1;

endpackage

// File: rtl/casino_game_selector_if.sv
// Board- and game-facing bus of the casino game selector. The slave modport
// is the selector itself; the master modport is whatever drives the board
// controls and hosts the game cores.
interface casino_game_selector_if #(
  parameter int N_GAMES = 3,
  parameter int BAL_W   = 16,
  parameter int DISP_W  = 56
);
  localparam int SEL_W = $clog2(N_GAMES);

  // Board side
  logic [SEL_W-1:0]          sel;
  logic                      sel_valid;
  logic                      start;
  logic [BAL_W-1:0]          bet;
  logic [DISP_W-1:0]         disp_out;
  logic [BAL_W-1:0]          balance;
  logic [SEL_W-1:0]          active_game;
  logic                      busy;
  logic [1:0]                error;

  // Game-core side
  logic [N_GAMES-1:0]        game_start;
  logic [BAL_W-1:0]          game_bet;
  logic [N_GAMES-1:0]        game_done;
  logic [N_GAMES-1:0]        game_win;
  logic [N_GAMES*BAL_W-1:0]  game_payout;
  logic [N_GAMES*DISP_W-1:0] game_disp;

  modport slave (
    input  sel, sel_valid, start, bet,
    input  game_done, game_win, game_payout, game_disp,
    output disp_out, balance, active_game, busy, error,
    output game_start, game_bet
  );

  modport master (
    output sel, sel_valid, start, bet,
    output game_done, game_win, game_payout, game_disp,
    input  disp_out, balance, active_game, busy, error,
    input  game_start, game_bet
  );

endinterface

// File: rtl/game_watchdog.sv
// Round watchdog: counts enabled cycles from a clear and flags the cycle in
// which the count has reached TIMEOUT-1, so a stuck game can be aborted.
module game_watchdog #(
  parameter int TIMEOUT = 2**20
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;

  // Count enabled cycles; clear wins so every round starts from zero.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments for all clocked state, so every register
    // samples pre-edge values regardless of statement order.
    if (reset_i || clear_i) begin
      cnt_q <= '0;
    end else if (enable_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expire_o = enable_i && !clear_i && (cnt_q == LAST);

endmodule

// File: rtl/casino_game_selector.sv
// Casino game selector: latches the player's game choice, gates start/bet to
// that game, owns the shared balance (debit at start, payout credit at end,
// refund on watchdog abort) and muxes the active game's display to the board.
module casino_game_selector
  import casino_pkg::*;
#(
  parameter int N_GAMES  = 3,
  parameter int BAL_W    = 16,
  parameter int DISP_W   = 56,
  parameter int INIT_BAL = 100,
  parameter int TIMEOUT  = 2**20
) (
  input logic                    clk_i,
  input logic                    reset_i,
  casino_game_selector_if.slave  bus
);
  localparam int SEL_W = $clog2(N_GAMES);
  localparam logic [SEL_W:0]        N_GAMES_W = (SEL_W + 1)'(N_GAMES);
  localparam logic [N_GAMES-1:0]    START_G0  = N_GAMES'(1);
  localparam logic [DISP_W-1:0]     BLANK     = DISP_BLANK[DISP_W-1:0];

  state_e             state_q;
  err_e               error_q;
  logic [BAL_W-1:0]   balance_q;
  logic [SEL_W-1:0]   active_q;
  logic [N_GAMES-1:0] game_start_q;
  logic [BAL_W-1:0]   game_bet_q;
  logic               busy_q;
  logic               win_q;
  logic [BAL_W-1:0]   payout_q;

  logic               sel_ok;
  logic               bet_ok;
  logic               act_done;
  logic               act_win;
  logic [BAL_W-1:0]   act_payout;
  logic [DISP_W-1:0]  act_disp;
  logic [BAL_W:0]     win_sum;
  logic [BAL_W-1:0]   win_bal;
  logic               wd_expire;

  assign sel_ok  = {1'b0, bus.sel} < N_GAMES_W;
  assign bet_ok  = (bus.bet != '0) && (bus.bet <= balance_q);

  // Payout credit saturates at the top of the balance range.
  assign win_sum = {1'b0, balance_q} + {1'b0, payout_q};
  assign win_bal = win_sum[BAL_W] ? '1 : win_sum[BAL_W-1:0];

  // Pick the active game's done/win/payout/display slices.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    act_done   = 1'b0;
    act_win    = 1'b0;
    act_payout = '0;
    act_disp   = BLANK;
    for (int g = 0; g < N_GAMES; g++) begin
      if (active_q == SEL_W'(g)) begin
        act_done   = bus.game_done[g];
        act_win    = bus.game_win[g];
        act_payout = bus.game_payout[g*BAL_W +: BAL_W];
        act_disp   = bus.game_disp[g*DISP_W +: DISP_W];
      end
    end
  end

  game_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .clear_i  (state_q != RUNNING),
    .enable_i (state_q == RUNNING),
    .expire_o (wd_expire)
  );

  // Round FSM with its registered outputs and the balance datapath.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      error_q      <= ERR_NONE;
      balance_q    <= BAL_W'(INIT_BAL);
      active_q     <= '0;
      game_start_q <= '0;
      game_bet_q   <= '0;
      busy_q       <= 1'b0;
      win_q        <= 1'b0;
      payout_q     <= '0;
    end else begin
      game_start_q <= '0;
      case (state_q)
        IDLE: begin
          if (bus.sel_valid) begin
            if (sel_ok) begin
              active_q <= bus.sel;
              error_q  <= ERR_NONE;
              state_q  <= ARMED;
            end else begin
              error_q  <= ERR_SEL;
            end
          end
        end
        ARMED: begin
          // A reselect takes priority over a start in the same cycle.
          if (bus.sel_valid) begin
            if (sel_ok) begin
              active_q <= bus.sel;
              error_q  <= ERR_NONE;
            end else begin
              error_q  <= ERR_SEL;
              state_q  <= IDLE;
            end
          end else if (bus.start) begin
            if (bet_ok) begin
              balance_q    <= balance_q - bus.bet;
              game_bet_q   <= bus.bet;
              game_start_q <= START_G0 << active_q;
              error_q      <= ERR_NONE;
              busy_q       <= 1'b1;
              state_q      <= RUNNING;
            end else begin
              error_q      <= ERR_BET;
            end
          end
        end
        RUNNING: begin
          // A done arriving on the expiry cycle still settles normally.
          if (act_done) begin
            win_q    <= act_win;
            payout_q <= act_payout;
            state_q  <= SETTLE;
          end else if (wd_expire) begin
            balance_q <= balance_q + game_bet_q;
            error_q   <= ERR_TIMEOUT;
            busy_q    <= 1'b0;
            state_q   <= ARMED;
          end
        end
        SETTLE: begin
          if (win_q) begin
            balance_q <= win_bal;
          end
          busy_q  <= 1'b0;
          state_q <= ARMED;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.disp_out    = (state_q == IDLE) ? BLANK : act_disp;
  assign bus.balance     = balance_q;
  assign bus.active_game = active_q;
  assign bus.busy        = busy_q;
  assign bus.error       = error_q;
  assign bus.game_start  = game_start_q;
  assign bus.game_bet    = game_bet_q;

endmodule

// File: tb/tb_casino_game_selector.sv
// Scoreboard bench for casino_game_selector: stimulus pushes hand-computed
// expected snapshots and start pulses into queues; a negedge monitor pops
// and compares them against the DUT outputs.
module tb_casino_game_selector;
  localparam int N_GAMES  = 3;
  localparam int BAL_W    = 16;
  localparam int DISP_W   = 56;
  localparam int INIT_BAL = 100;
  localparam int TIMEOUT  = 16;

  localparam logic [55:0] DISP0 = 56'h11111111111111;
  localparam logic [55:0] DISP1 = 56'h22222222222222;
  localparam logic [55:0] DISP2 = 56'h33333333333333;
  localparam logic [55:0] BLANK = 56'hFFFFFFFFFFFFFF;

  logic clk_i   = 1'b0;
  logic reset_i = 1'b1;

  always #5 clk_i = ~clk_i;

  casino_game_selector_if #(
    .N_GAMES (N_GAMES), .BAL_W (BAL_W), .DISP_W (DISP_W)
  ) bus ();

  casino_game_selector #(
    .N_GAMES  (N_GAMES),
    .BAL_W    (BAL_W),
    .DISP_W   (DISP_W),
    .INIT_BAL (INIT_BAL),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  typedef struct {
    string       name;
    logic [15:0] bal;
    logic        busy;
    logic [1:0]  err;
    logic [1:0]  act;
    logic [55:0] disp;
    logic [2:0]  gs;
  } snap_t;

  typedef struct {
    logic [2:0]  gs;
    logic [15:0] bet;
  } start_t;

  snap_t  snap_q[$];
  start_t start_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: compare queued snapshots and every game_start pulse.
  always @(negedge clk_i) begin : monitor
    snap_t  s;
    start_t p;
    while (snap_q.size() > 0) begin
      s = snap_q.pop_front();
      check({s.name, ".balance"},     bus.balance,     s.bal);
      check({s.name, ".busy"},        bus.busy,        s.busy);
      check({s.name, ".error"},       bus.error,       s.err);
      check({s.name, ".active_game"}, bus.active_game, s.act);
      check({s.name, ".disp_out"},    bus.disp_out,    s.disp);
      check({s.name, ".game_start"},  bus.game_start,  s.gs);
    end
    if (bus.game_start !== '0) begin
      if (start_q.size() == 0) begin
        check("unexpected_start", bus.game_start, 0);
      end else begin
        p = start_q.pop_front();
        check("start_pulse.onehot", bus.game_start, p.gs);
        check("start_pulse.bet",    bus.game_bet,   p.bet);
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic expect_state(input string name, input logic [15:0] bal, input logic busy,
                              input logic [1:0] err, input logic [1:0] act,
                              input logic [55:0] disp, input logic [2:0] gs);
    snap_t s;
    s.name = name; s.bal = bal; s.busy = busy; s.err = err;
    s.act = act; s.disp = disp; s.gs = gs;
    snap_q.push_back(s);
  endtask

  task automatic pulse_sel(input logic [1:0] s);
    bus.sel = s;
    bus.sel_valid = 1'b1;
    tick();
    bus.sel_valid = 1'b0;
  endtask

  task automatic pulse_start(input logic [15:0] b, input logic accept, input logic [2:0] gs);
    start_t p;
    if (accept) begin
      p.gs = gs; p.bet = b;
      start_q.push_back(p);
    end
    bus.bet = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic pulse_done(input int g, input logic win, input logic [15:0] payout);
    bus.game_done = 3'b001 << g;
    bus.game_win  = {2'b00, win} << g;
    bus.game_payout[g*16 +: 16] = payout;
    tick();
    bus.game_done = '0;
    bus.game_win  = '0;
  endtask

  initial begin
    bus.sel = '0; bus.sel_valid = 1'b0; bus.start = 1'b0; bus.bet = '0;
    bus.game_done = '0; bus.game_win = '0; bus.game_payout = '0;
    bus.game_disp = {DISP2, DISP1, DISP0};

    reset_i = 1'b1;
    tick(); tick();
    reset_i = 1'b0;
    expect_state("reset", 16'd100, 1'b0, 2'd0, 2'd0, BLANK, 3'b000);

    // Basic round on game 1: debit 30, win 60.
    pulse_sel(2'd1);
    expect_state("sel1", 16'd100, 1'b0, 2'd0, 2'd1, DISP1, 3'b000);
    pulse_start(16'd30, 1'b1, 3'b010);
    expect_state("start30", 16'd70, 1'b1, 2'd0, 2'd1, DISP1, 3'b010);
    tick();
    expect_state("start_pulse_end", 16'd70, 1'b1, 2'd0, 2'd1, DISP1, 3'b000);
    pulse_done(1, 1'b1, 16'd60);
    expect_state("settle_win60", 16'd70, 1'b1, 2'd0, 2'd1, DISP1, 3'b000);
    tick();
    expect_state("armed_130", 16'd130, 1'b0, 2'd0, 2'd1, DISP1, 3'b000);

    // Error paths.
    pulse_sel(2'd3);
    expect_state("bad_sel", 16'd130, 1'b0, 2'd1, 2'd1, BLANK, 3'b000);
    pulse_start(16'd10, 1'b0, 3'b000);
    expect_state("start_in_idle", 16'd130, 1'b0, 2'd1, 2'd1, BLANK, 3'b000);
    pulse_sel(2'd0);
    expect_state("sel0", 16'd130, 1'b0, 2'd0, 2'd0, DISP0, 3'b000);
    pulse_start(16'd0, 1'b0, 3'b000);
    expect_state("bet_zero", 16'd130, 1'b0, 2'd2, 2'd0, DISP0, 3'b000);
    pulse_start(16'd200, 1'b0, 3'b000);
    expect_state("bet_over", 16'd130, 1'b0, 2'd2, 2'd0, DISP0, 3'b000);

    // sel_valid and start together: reselect wins, start dropped.
    bus.sel = 2'd2; bus.sel_valid = 1'b1; bus.bet = 16'd10; bus.start = 1'b1;
    tick();
    bus.sel_valid = 1'b0; bus.start = 1'b0;
    expect_state("sel_beats_start", 16'd130, 1'b0, 2'd0, 2'd2, DISP2, 3'b000);

    // Isolation and lock while running on game 0.
    pulse_sel(2'd0);
    pulse_start(16'd20, 1'b1, 3'b001);
    expect_state("start20", 16'd110, 1'b1, 2'd0, 2'd0, DISP0, 3'b001);
    pulse_done(2, 1'b1, 16'd50);
    expect_state("foreign_done", 16'd110, 1'b1, 2'd0, 2'd0, DISP0, 3'b000);
    tick();
    expect_state("foreign_done_2", 16'd110, 1'b1, 2'd0, 2'd0, DISP0, 3'b000);
    pulse_sel(2'd2);
    expect_state("sel_locked", 16'd110, 1'b1, 2'd0, 2'd0, DISP0, 3'b000);
    pulse_done(0, 1'b0, 16'd99);
    tick();
    expect_state("loss", 16'd110, 1'b0, 2'd0, 2'd0, DISP0, 3'b000);

    // Watchdog abort refunds the bet.
    pulse_start(16'd40, 1'b1, 3'b001);
    expect_state("start40", 16'd70, 1'b1, 2'd0, 2'd0, DISP0, 3'b001);
    repeat (15) tick();
    expect_state("wd_not_yet", 16'd70, 1'b1, 2'd0, 2'd0, DISP0, 3'b000);
    tick();
    expect_state("wd_expired", 16'd110, 1'b0, 2'd3, 2'd0, DISP0, 3'b000);

    // Done on the expiry cycle wins over the timeout.
    pulse_start(16'd40, 1'b1, 3'b001);
    repeat (15) tick();
    pulse_done(0, 1'b1, 16'd80);
    expect_state("done_at_expiry", 16'd70, 1'b1, 2'd0, 2'd0, DISP0, 3'b000);
    tick();
    expect_state("done_at_expiry_paid", 16'd150, 1'b0, 2'd0, 2'd0, DISP0, 3'b000);

    // Saturation at 65535.
    pulse_start(16'd1, 1'b1, 3'b001);
    pulse_done(0, 1'b1, 16'd65351);
    tick();
    expect_state("bal_65500", 16'd65500, 1'b0, 2'd0, 2'd0, DISP0, 3'b000);
    pulse_start(16'd1, 1'b1, 3'b001);
    pulse_done(0, 1'b1, 16'd100);
    tick();
    expect_state("saturate", 16'd65535, 1'b0, 2'd0, 2'd0, DISP0, 3'b000);

    // Reset mid-round: no refund, back to initial state.
    pulse_start(16'd35, 1'b1, 3'b001);
    expect_state("start35", 16'd65500, 1'b1, 2'd0, 2'd0, DISP0, 3'b001);
    tick();
    reset_i = 1'b1;
    tick();
    expect_state("reset_mid_round", 16'd100, 1'b0, 2'd0, 2'd0, BLANK, 3'b000);
    reset_i = 1'b0;
    tick();
    @(negedge clk_i);
    #1;
    check("start_q_drained", start_q.size(), 0);
    check("snap_q_drained",  snap_q.size(),  0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/casino_game_selector.md
Name: casino_game_selector

Overview:
- Parametrised front-end that lets the player pick one of N_GAMES casino games (default: 0 BlackJack, 1 roulette number, 2 roulette even/odd), locks the choice while a round runs, and routes start/bet to the chosen game.
- Muxes the chosen game's display back to the board and owns the shared player balance: debits the bet at round start and credits the payout at round end.
- Adds a watchdog that aborts a stuck game and refunds the bet.
- Sits between board I/O (SW/KEY/HEX) and the per-game cores.

Parameters:
- N_GAMES, 3, number of attached game cores (2..8)
- SEL_W, $clog2(N_GAMES), width of game index (derived; not overridden)
- BAL_W, 16, balance/bet/payout width (unsigned)
- DISP_W, 56, per-game display bus width (8 digits x 7 segments, active-low)
- INIT_BAL, 100, balance after reset
- TIMEOUT, 2**20, cycles in RUNNING before watchdog abort

Ports:
- Clock  in  1  system clock; all state on rising edge
- reset  in  1  synchronous, active-high reset
- sel  in  SEL_W  requested game index
- sel_valid  in  1  one-cycle pulse: latch sel
- start  in  1  one-cycle pulse: start round with bet
- bet  in  BAL_W  wager for this round
- game_start  out  N_GAMES  one-hot start pulse to the active game
- game_bet  out  BAL_W  bet latched at start, held until next start
- game_done  in  N_GAMES  per-game round-complete pulse
- game_win  in  N_GAMES  per-game win flag, valid with game_done
- game_payout  in  N_GAMES*BAL_W  per-game payout (slice i = game i), valid with game_done
- game_disp  in  N_GAMES*DISP_W  per-game display buses
- disp_out  out  DISP_W  muxed display
- balance  out  BAL_W  current player balance
- active_game  out  SEL_W  latched game index
- busy  out  1  high in RUNNING and SETTLE
- error  out  2  0 none, 1 bad select, 2 bad bet, 3 timeout

Behaviour:
- Reset values:
  - State IDLE; balance = INIT_BAL; active_game = 0; game_start = 0; game_bet = 0; busy = 0; error = 0; watchdog = 0.
  - disp_out = all ones (blank).
- IDLE:
  - sel_valid with sel < N_GAMES: latch active_game, go to ARMED, clear error.
  - sel_valid with sel >= N_GAMES: stay in IDLE, error = 1.
  - start is ignored.
- ARMED:
  - sel_valid is handled as in IDLE. A bad sel returns to IDLE.
  - start with bet == 0 or bet > balance: stay in ARMED, error = 2.
  - Otherwise, on that same edge:
    - balance <= balance - bet; game_bet <= bet.
    - game_start[active_game] <= 1 for exactly one cycle.
    - error <= 0; watchdog <= 0; go to RUNNING.
  - sel_valid and start in the same cycle: sel_valid wins, start is dropped.
- RUNNING:
  - sel_valid and start are ignored.
  - game_done from non-active games is ignored.
  - game_done[active_game]: latch win and payout slice, go to SETTLE.
  - Watchdog increments each cycle. When it reaches TIMEOUT-1 without done: balance += game_bet (refund), error = 3, go to ARMED.
  - done and timeout in the same cycle: done wins.
- SETTLE (exactly 1 cycle):
  - If win: balance <= balance + payout, saturating at 2**BAL_W-1.
  - Go to ARMED, so the same game can be replayed without reselecting.
- Round latency: start edge to RUNNING is 1 cycle; done edge to balance update is 2 edges (RUNNING->SETTLE, SETTLE->ARMED).
- disp_out:
  - IDLE: blank (all ones).
  - All other states: combinational slice of game_disp for active_game.
- busy is registered and tracks the RUNNING/SETTLE states.
- error is sticky until overwritten as listed above.
- Reset mid-round: the round is abandoned with no refund; balance returns to INIT_BAL.
- Arithmetic:
  - All unsigned BAL_W.
  - The debit cannot underflow, because bet > balance is rejected.
  - Refund cannot overflow, because it restores a value held earlier.

Decomposition:
- Shared package casino_pkg holds:
  - state enum {IDLE, ARMED, RUNNING, SETTLE}
  - error codes ERR_NONE/ERR_SEL/ERR_BET/ERR_TIMEOUT
  - DISP_BLANK constant
- One sub-module, game_watchdog:
  - Counter parameterised by TIMEOUT; inputs clear/enable; output expire pulse.
- Display mux and balance datapath stay in the top module.

Test Plan:
- Reset, then sel_valid sel=1 -> ARMED, active_game=1, balance=100, disp_out = game_disp slice 1.
- start bet=30 -> next cycle game_start=3'b010 for 1 cycle, balance=70, busy=1. Then game_done[1]=1, win=1, payout=60 -> after 2 edges balance=130, state ARMED, busy=0.
- Error paths:
  - sel_valid sel=3 (N_GAMES=3) -> error=1, state IDLE.
  - In ARMED, start bet=0 -> error=2.
  - start bet=200 with balance 100 -> error=2, balance unchanged.
- Isolation and lock:
  - In RUNNING on game 0, pulse game_done[2] -> ignored, stays RUNNING.
  - sel_valid sel=2 during RUNNING -> active_game unchanged.
- TIMEOUT=16, start bet=40, no done -> after 16 cycles balance back to 100, error=3, state ARMED. Repeat with done arriving on the expiry cycle -> settles normally, error=0.
- Edge cases:
  - balance=65500, win payout=100 -> balance saturates at 65535.
  - Assert reset during RUNNING -> balance=100, IDLE, game_start=0.
